qbus_dma_master_2908: RTL and testbench
=======================================

Name: qbus_dma_master_2908

Overview:
QBUS DMA bus-master sequencer for the PMo/Ztex board with Am2908 DAL buffers. It is the initiator counterpart of the slave/register controller: it arbitrates for the bus (DMR/DMG/SACK) and runs single-word DATI or DATO cycles on behalf of an internal DMA client. It feeds the slave controller's dma_* DAL-mux inputs, which own the Am2908 and ZDAL pins.

Parameters:
ADDR_SETUP, 3, clocks of address valid on BDAL before TSYNC asserts (150 ns at 20 MHz)
ADDR_HOLD, 2, clocks of address held after TSYNC asserts
DATA_SETUP, 2, clocks of DATO data valid before TDOUT asserts
DIN_SETTLE, 2, clocks after synchronized RRPLY before dal_in is sampled (ribbon-cable settle)
TIMEOUT, 200, clocks waiting for RRPLY before bus error (10 us)

Ports:
clk  in  1  20 MHz system clock
reset  in  1  synchronous, active-high reset
RDMGI  in  1  DMA grant in (daisy chain)
RSYNC  in  1  bus SYNC as received
RRPLY  in  1  bus RPLY as received
RINIT  in  1  bus INIT
TDMR  out  1  DMA request
TSACK  out  1  selection acknowledge
TDMGO  out  1  DMA grant out (daisy chain)
TSYNC  out  1  SYNC drive
TDIN  out  1  DIN drive
TDOUT  out  1  DOUT drive
dma_assert_dal  out  1  select dma_dal into the slave controller's DAL mux
dma_dal  out  22  address/data to transmit
dma_dalbe  out  1  enable Am2908 bus drivers
dma_daltx  out  1  set level shifters to transmit
dma_dalst  out  1  latch pulse for Am2908 output register
dma_wtbt  out  1  WTBT value during address phase (1 = write)
dal_in  in  16  received BDAL data from the Am2908 receive path
req  in  1  client request; level, held until done or err
write  in  1  1 = DATO, 0 = DATI; sampled with req in IDLE
addr  in  22  word address; sampled with req in IDLE
wdata  in  16  DATO data; sampled with req in IDLE
rdata  out  16  DATI result; valid when done
done  out  1  one-clock pulse, cycle completed
err  out  1  one-clock pulse, RPLY timeout

Behaviour:
- One clock (clk); reset is synchronous and active-high. Reset: all outputs 0, rdata 0, state IDLE.
- RDMGI, RSYNC, RRPLY, RINIT pass through 2-FF synchronizers (sX = stage 2); all decisions use these.
- TDMGO = sRDMGI while state is IDLE and req=0, else 0 (grant is not passed once we are requesting).
- States:
 IDLE: when req=1, latch write/addr/wdata and go to REQ.
 REQ: TDMR=1. On sRDMGI=1, go to ACK.
 ACK: TSACK=1, TDMR=0. Wait until sRSYNC=0 and sRRPLY=0, then go to ADDR.
 ADDR: dma_assert_dal=1, dma_daltx=1, dma_dal=addr, dma_wtbt=write. dma_dalst pulses on the first clock; dma_dalbe=1 from the second clock. After ADDR_SETUP clocks, go to SYNC.
 SYNC: TSYNC=1 and remains 1 until END. Hold the address ADDR_HOLD clocks, then go to DOUT_SETUP if write, else DIN.
 DOUT_SETUP: dma_dal={6'b0,wdata}, dma_dalst pulses once, dma_wtbt=0, dma_dalbe stays 1. After DATA_SETUP clocks, go to DOUT.
 DOUT: TDOUT=1. On sRRPLY=1, go to RPLY_REL.
 DIN: dma_assert_dal, dma_daltx, dma_dalbe = 0; TDIN=1. On sRRPLY=1, wait DIN_SETTLE clocks, capture rdata=dal_in, go to RPLY_REL.
 RPLY_REL: TDIN and TDOUT = 0 and DAL drive released. When sRRPLY=0, go to END.
 END: TSYNC=0, TSACK=0, pulse done, go to IDLE.
- Timeout: a counter starts when TDIN or TDOUT asserts. Reaching TIMEOUT clocks with sRRPLY still 0 negates all bus outputs, pulses err (no done), and returns to IDLE.
- sRINIT=1 in any state: same effect as reset on the next clock, with no done or err. The block stays in IDLE while sRINIT=1.
- Never assert TSYNC while sRSYNC was seen 1 in ACK (bus-free check above). TDIN and TDOUT are mutually exclusive.
- req dropped mid-cycle is ignored; the cycle completes. At most one transfer per grant (no block mode; TREF is not driven).

Decomposition:
- Shared package (qsic.vh): state encodings and the default timing constants ADDR_SETUP, DATA_SETUP, TIMEOUT.
- Natural sub-module: qbus_sync2, a 2-FF synchronizer parameterized by width, used for RDMGI/RSYNC/RRPLY/RINIT.

Test Plan:
- DATO: req, write=1, addr=22'o17772, wdata=16'o123456; bench grants DMG after 5 clocks and replies RPLY 10 clocks after TDOUT -> address then data latched via dma_dalst, TSYNC asserted 3 clocks after address, single done pulse, TSACK and TSYNC both 0 afterward.
- DATI: req, write=0, addr=22'o1000; slave drives dal_in=16'o052525 with RPLY -> TDIN asserted with DAL released, rdata=16'o052525 on done.
- Bus busy: RSYNC held 1 by another master when DMG arrives -> TSACK=1 but no TSYNC until RSYNC drops; then the cycle proceeds normally.
- Timeout: RRPLY never asserted -> err pulses at TIMEOUT+sync latency clocks after TDIN; all T* outputs and dma_* outputs 0; no done.
- Daisy chain: req=0 with RDMGI=1 -> TDMGO=1 after 2 clocks; with req=1, RDMGI=1 -> TDMGO stays 0 and TSACK=1.
- RINIT asserted during DOUT -> all outputs 0 within 3 clocks, state IDLE, no done or err; a new req after INIT negates completes normally.

Source files
------------

// File: rtl/qbus_dma_master_2908_pkg.sv
// rtl/qbus_dma_master_2908_pkg.sv - shared states and timing defaults for the QBUS DMA master
package qbus_dma_master_2908_pkg;

    // Default bus timing, in 20 MHz clocks
    localparam int DEF_ADDR_SETUP = 3;   // 150 ns address valid before TSYNC
    localparam int DEF_ADDR_HOLD  = 2;   // address hold after TSYNC
    localparam int DEF_DATA_SETUP = 2;   // DATO data valid before TDOUT
    localparam int DEF_DIN_SETTLE = 2;   // ribbon-cable settle after RPLY
    localparam int DEF_TIMEOUT    = 200; // 10 us RPLY timeout

    localparam int CNT_W = 16;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_REQ,
        ST_ACK,
        ST_ADDR,
        ST_SYNC,
        ST_DOUT_SETUP,
        ST_DOUT,
        ST_DIN,
        ST_RPLY_REL,
        ST_END
    } dma_state_e;

endpackage

// File: rtl/qbus_dma_master_2908_if.sv
// rtl/qbus_dma_master_2908_if.sv - QBUS arbitration/handshake and DAL-mux signal bundle
interface qbus_dma_master_2908_if;
    logic        RDMGI;
    logic        RSYNC;
    logic        RRPLY;
    logic        RINIT;
    logic        TDMR;
    logic        TSACK;
    logic        TDMGO;
    logic        TSYNC;
    logic        TDIN;
    logic        TDOUT;
    logic        dma_assert_dal;
    logic [21:0] dma_dal;
    logic        dma_dalbe;
    logic        dma_daltx;
    logic        dma_dalst;
    logic        dma_wtbt;
    logic [15:0] dal_in;

    modport master (
        input  RDMGI, RSYNC, RRPLY, RINIT, dal_in,
        output TDMR, TSACK, TDMGO, TSYNC, TDIN, TDOUT,
        output dma_assert_dal, dma_dal, dma_dalbe, dma_daltx, dma_dalst, dma_wtbt
    );

    modport slave (
        output RDMGI, RSYNC, RRPLY, RINIT, dal_in,
        input  TDMR, TSACK, TDMGO, TSYNC, TDIN, TDOUT,
        input  dma_assert_dal, dma_dal, dma_dalbe, dma_daltx, dma_dalst, dma_wtbt
    );
endinterface

// File: rtl/qbus_dma_master_2908_sync2.sv
// rtl/qbus_dma_master_2908_sync2.sv - two-flop synchronizer for asynchronous bus inputs
module qbus_dma_master_2908_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;

    // Two-stage metastability filter; only stage 2 is used by the logic
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/qbus_dma_master_2908.sv
// rtl/qbus_dma_master_2908.sv - QBUS DMA bus-master sequencer for single-word DATI/DATO
module qbus_dma_master_2908
    import qbus_dma_master_2908_pkg::*;
#(
    parameter int ADDR_SETUP = DEF_ADDR_SETUP,
    parameter int ADDR_HOLD  = DEF_ADDR_HOLD,
    parameter int DATA_SETUP = DEF_DATA_SETUP,
    parameter int DIN_SETTLE = DEF_DIN_SETTLE,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                          clk,
    input  logic                          reset,
    qbus_dma_master_2908_if.master        bus,
    input  logic                          req,
    input  logic                          write,
    input  logic [21:0]                   addr,
    input  logic [15:0]                   wdata,
    output logic [15:0]                   rdata,
    output logic                          done,
    output logic                          err
);

    logic [3:0] s_vec;
    logic       s_dmgi, s_sync, s_rply, s_init;

    qbus_dma_master_2908_sync2 #(.W(4)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   ({bus.RDMGI, bus.RSYNC, bus.RRPLY, bus.RINIT}),
        .q_o   (s_vec)
    );

    assign {s_dmgi, s_sync, s_rply, s_init} = s_vec;

    dma_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] tmo_q;
    logic             settle_q;
    logic             write_q;
    logic [21:0]      addr_q;
    logic [15:0]      wdata_q;

    logic             tdmr_q, tsack_q, tsync_q, tdin_q, tdout_q;
    logic             assert_q, dalbe_q, daltx_q, dalst_q, wtbt_q;
    logic [21:0]      dal_q;
    logic [15:0]      rdata_q;
    logic             done_q, err_q;
    logic             tmo_hit;

    // RPLY has not arrived within the timeout window while DIN/DOUT is driven
    assign tmo_hit = !s_rply && (tmo_q == CNT_W'(TIMEOUT - 1)) &&
                     ((state_q == ST_DOUT) || (state_q == ST_DIN && !settle_q));

    // Bus-master sequencer: arbitration, address phase, data phase, release
    always_ff @(posedge clk) begin
        if (reset || s_init || tmo_hit) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            tmo_q    <= '0;
            settle_q <= 1'b0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            tdmr_q   <= 1'b0;
            tsack_q  <= 1'b0;
            tsync_q  <= 1'b0;
            tdin_q   <= 1'b0;
            tdout_q  <= 1'b0;
            assert_q <= 1'b0;
            dalbe_q  <= 1'b0;
            daltx_q  <= 1'b0;
            dalst_q  <= 1'b0;
            wtbt_q   <= 1'b0;
            dal_q    <= '0;
            rdata_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= tmo_hit && !reset && !s_init;
        end else begin
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            dalst_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        write_q <= write;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        tdmr_q  <= 1'b1;
                        state_q <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (s_dmgi) begin
                        tdmr_q  <= 1'b0;
                        tsack_q <= 1'b1;
                        state_q <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    // Previous bus master must have finished its cycle
                    if (!s_sync && !s_rply) begin
                        assert_q <= 1'b1;
                        daltx_q  <= 1'b1;
                        dal_q    <= addr_q;
                        wtbt_q   <= write_q;
                        dalst_q  <= 1'b1;
                        cnt_q    <= CNT_W'(1);
                        state_q  <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    // Latch pulse came first; drivers turn on once the register holds the address
                    dalbe_q <= 1'b1;
                    if (cnt_q == CNT_W'(ADDR_SETUP)) begin
                        tsync_q <= 1'b1;
                        cnt_q   <= CNT_W'(1);
                        state_q <= ST_SYNC;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_SYNC: begin
                    if (cnt_q == CNT_W'(ADDR_HOLD)) begin
                        if (write_q) begin
                            dal_q   <= {6'b0, wdata_q};
                            dalst_q <= 1'b1;
                            wtbt_q  <= 1'b0;
                            cnt_q   <= CNT_W'(1);
                            state_q <= ST_DOUT_SETUP;
                        end else begin
                            assert_q <= 1'b0;
                            daltx_q  <= 1'b0;
                            dalbe_q  <= 1'b0;
                            wtbt_q   <= 1'b0;
                            tdin_q   <= 1'b1;
                            tmo_q    <= '0;
                            settle_q <= 1'b0;
                            state_q  <= ST_DIN;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DOUT_SETUP: begin
                    if (cnt_q == CNT_W'(DATA_SETUP)) begin
                        tdout_q <= 1'b1;
                        tmo_q   <= '0;
                        state_q <= ST_DOUT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DOUT: begin
                    if (s_rply) begin
                        tdout_q  <= 1'b0;
                        assert_q <= 1'b0;
                        daltx_q  <= 1'b0;
                        dalbe_q  <= 1'b0;
                        state_q  <= ST_RPLY_REL;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                ST_DIN: begin
                    if (settle_q) begin
                        if (cnt_q == CNT_W'(DIN_SETTLE)) begin
                            rdata_q <= bus.dal_in;
                            tdin_q  <= 1'b0;
                            state_q <= ST_RPLY_REL;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else if (s_rply) begin
                        settle_q <= 1'b1;
                        cnt_q    <= CNT_W'(1);
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                ST_RPLY_REL: begin
                    if (!s_rply) begin
                        tsync_q <= 1'b0;
                        tsack_q <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_END;
                    end
                end
                ST_END: begin
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Grant passes down the chain only while we are idle and not requesting
    assign bus.TDMGO = (state_q == ST_IDLE) && !req && s_dmgi;

    assign bus.TDMR           = tdmr_q;
    assign bus.TSACK          = tsack_q;
    assign bus.TSYNC          = tsync_q;
    assign bus.TDIN           = tdin_q;
    assign bus.TDOUT          = tdout_q;
    assign bus.dma_assert_dal = assert_q;
    assign bus.dma_dal        = dal_q;
    assign bus.dma_dalbe      = dalbe_q;
    assign bus.dma_daltx      = daltx_q;
    assign bus.dma_dalst      = dalst_q;
    assign bus.dma_wtbt       = wtbt_q;
    assign rdata              = rdata_q;
    assign done               = done_q;
    assign err                = err_q;

endmodule

// File: tb/tb_qbus_dma_master_2908.sv
// tb/tb_qbus_dma_master_2908.sv - directed self-checking bench for the QBUS DMA master
module tb_qbus_dma_master_2908;

    localparam int BUDGET = 400;

    localparam int W_TSACK = 0;
    localparam int W_TSYNC = 1;
    localparam int W_TDIN  = 2;
    localparam int W_TDOUT = 3;
    localparam int W_DALST = 4;
    localparam int W_DONE  = 5;
    localparam int W_ERR   = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        write;
    logic [21:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int excl_cnt = 0;
    int n;

    qbus_dma_master_2908_if bus_if ();

    qbus_dma_master_2908 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if),
        .req   (req),
        .write (write),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .done  (done),
        .err   (err)
    );

    always #25 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            if (done) done_cnt++;
            if (err) err_cnt++;
            if (bus_if.TDIN && bus_if.TDOUT) excl_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] all_outs();
        return {bus_if.TDMR, bus_if.TSACK, bus_if.TDMGO, bus_if.TSYNC, bus_if.TDIN,
                bus_if.TDOUT, bus_if.dma_assert_dal, bus_if.dma_dalbe, bus_if.dma_daltx,
                bus_if.dma_dalst, bus_if.dma_wtbt};
    endfunction

    function automatic logic get_sig(input int which);
        case (which)
            W_TSACK: return bus_if.TSACK;
            W_TSYNC: return bus_if.TSYNC;
            W_TDIN:  return bus_if.TDIN;
            W_TDOUT: return bus_if.TDOUT;
            W_DALST: return bus_if.dma_dalst;
            W_DONE:  return done;
            W_ERR:   return err;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_until(input int which, input logic val, input string tag, output int cnt);
        cnt = 0;
        while (get_sig(which) !== val && cnt < BUDGET) begin
            tick();
            cnt++;
        end
        if (cnt >= BUDGET) check({tag, "_timeout"}, 32'(get_sig(which)), 32'(val));
    endtask

    task automatic start(input logic w, input logic [21:0] a, input logic [15:0] d);
        write = w;
        addr  = a;
        wdata = d;
        req   = 1'b1;
    endtask

    task automatic grant(input string tag);
        int k;
        bus_if.RDMGI = 1'b1;
        wait_until(W_TSACK, 1'b1, tag, k);
        bus_if.RDMGI = 1'b0;
    endtask

    task automatic complete_write(input string tag);
        int k;
        wait_until(W_TDOUT, 1'b1, {tag, "_tdout"}, k);
        repeat (3) tick();
        bus_if.RRPLY = 1'b1;
        wait_until(W_TDOUT, 1'b0, {tag, "_rel"}, k);
        bus_if.RRPLY = 1'b0;
        wait_until(W_DONE, 1'b1, {tag, "_done"}, k);
        req = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        reset = 1'b1;
        req = 1'b0;
        write = 1'b0;
        addr = '0;
        wdata = '0;
        bus_if.RDMGI = 1'b0;
        bus_if.RSYNC = 1'b0;
        bus_if.RRPLY = 1'b0;
        bus_if.RINIT = 1'b0;
        bus_if.dal_in = '0;
        repeat (3) tick();
        check("reset_outs", 32'(all_outs()), 32'h0);
        check("reset_rdata", 32'(rdata), 32'h0);
        check("reset_done_err", 32'({done, err}), 32'h0);
        reset = 1'b0;
        tick();

        // DATO to 17772 with data 123456
        start(1'b1, 22'o17772, 16'o123456);
        tick();
        check("dato_tdmr", 32'(bus_if.TDMR), 32'h1);
        repeat (5) tick();
        grant("dato_grant");
        check("dato_tdmr_off", 32'(bus_if.TDMR), 32'h0);
        wait_until(W_DALST, 1'b1, "dato_addr_st", n);
        check("dato_addr", 32'(bus_if.dma_dal), 32'o17772);
        check("dato_addr_ctl", 32'({bus_if.dma_assert_dal, bus_if.dma_daltx, bus_if.dma_wtbt, bus_if.dma_dalbe}), 32'b1110);
        wait_until(W_TSYNC, 1'b1, "dato_tsync", n);
        check("dato_tsync_lat", 32'(n), 32'd3);
        check("dato_dalbe", 32'(bus_if.dma_dalbe), 32'h1);
        wait_until(W_DALST, 1'b1, "dato_data_st", n);
        check("dato_data", 32'(bus_if.dma_dal), 32'o123456);
        check("dato_wtbt", 32'(bus_if.dma_wtbt), 32'h0);
        wait_until(W_TDOUT, 1'b1, "dato_tdout", n);
        check("dato_tdout_lat", 32'(n), 32'd2);
        check("dato_tdin_off", 32'(bus_if.TDIN), 32'h0);
        repeat (10) tick();
        bus_if.RRPLY = 1'b1;
        wait_until(W_TDOUT, 1'b0, "dato_rel", n);
        check("dato_rel_dal", 32'({bus_if.dma_assert_dal, bus_if.dma_dalbe}), 32'h0);
        bus_if.RRPLY = 1'b0;
        wait_until(W_DONE, 1'b1, "dato_done", n);
        check("dato_end_bus", 32'({bus_if.TSYNC, bus_if.TSACK}), 32'h0);
        req = 1'b0;
        repeat (3) tick();
        check("dato_after", 32'(all_outs()), 32'h0);
        check("dato_done_cnt", 32'(done_cnt), 32'd1);

        // DATI from 1000 returning 052525
        start(1'b0, 22'o1000, 16'h0);
        repeat (2) tick();
        grant("dati_grant");
        wait_until(W_TDIN, 1'b1, "dati_tdin", n);
        check("dati_dal_rel", 32'({bus_if.dma_assert_dal, bus_if.dma_daltx, bus_if.dma_dalbe, bus_if.TDOUT}), 32'h0);
        check("dati_tsync", 32'(bus_if.TSYNC), 32'h1);
        repeat (3) tick();
        bus_if.dal_in = 16'o052525;
        bus_if.RRPLY = 1'b1;
        wait_until(W_TDIN, 1'b0, "dati_capture", n);
        bus_if.RRPLY = 1'b0;
        bus_if.dal_in = 16'h0;
        wait_until(W_DONE, 1'b1, "dati_done", n);
        check("dati_rdata", 32'(rdata), 32'o052525);
        req = 1'b0;
        repeat (2) tick();
        check("dati_done_cnt", 32'(done_cnt), 32'd2);

        // Another master still holds SYNC when the grant arrives
        bus_if.RSYNC = 1'b1;
        start(1'b1, 22'o2000, 16'o1);
        tick();
        grant("busy_grant");
        repeat (10) tick();
        check("busy_wait", 32'({bus_if.TSACK, bus_if.TSYNC, bus_if.dma_assert_dal}), 32'b100);
        bus_if.RSYNC = 1'b0;
        wait_until(W_TSYNC, 1'b1, "busy_tsync", n);
        check("busy_addr", 32'(bus_if.dma_dal), 32'o2000);
        complete_write("busy");
        check("busy_done_cnt", 32'(done_cnt), 32'd3);

        // No reply: timeout must abort with err only
        start(1'b0, 22'o3000, 16'h0);
        tick();
        grant("tmo_grant");
        wait_until(W_TDIN, 1'b1, "tmo_tdin", n);
        wait_until(W_ERR, 1'b1, "tmo_err", n);
        req = 1'b0;
        check("tmo_lat", 32'(n >= 200 && n <= 203), 32'h1);
        check("tmo_outs", 32'(all_outs()), 32'h0);
        tick();
        tick();
        check("tmo_err_cnt", 32'(err_cnt), 32'd1);
        check("tmo_no_done", 32'(done_cnt), 32'd3);

        // Daisy chain pass-through versus capture
        bus_if.RDMGI = 1'b1;
        tick();
        check("chain_1clk", 32'(bus_if.TDMGO), 32'h0);
        tick();
        check("chain_2clk", 32'(bus_if.TDMGO), 32'h1);
        start(1'b1, 22'o4000, 16'o7);
        wait_until(W_TSACK, 1'b1, "chain_sack", n);
        check("chain_blocked", 32'({bus_if.TDMGO, bus_if.TSACK}), 32'b01);
        bus_if.RDMGI = 1'b0;
        complete_write("chain");
        check("chain_done_cnt", 32'(done_cnt), 32'd4);

        // INIT during DOUT
        start(1'b1, 22'o5000, 16'o55);
        tick();
        grant("init_grant");
        wait_until(W_TDOUT, 1'b1, "init_tdout", n);
        bus_if.RINIT = 1'b1;
        repeat (3) tick();
        check("init_outs", 32'(all_outs()), 32'h0);
        req = 1'b0;
        repeat (3) tick();
        bus_if.RINIT = 1'b0;
        repeat (4) tick();
        check("init_no_pulse", 32'({done_cnt, err_cnt}), 32'({32'd4, 32'd1}));
        start(1'b1, 22'o6000, 16'o123);
        tick();
        grant("post_init_grant");
        wait_until(W_DALST, 1'b1, "post_init_st", n);
        check("post_init_addr", 32'(bus_if.dma_dal), 32'o6000);
        complete_write("post_init");
        check("post_init_done", 32'(done_cnt), 32'd5);
        check("err_total", 32'(err_cnt), 32'd1);
        check("tdin_tdout_excl", 32'(excl_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
